// File: rtl/br_arb_rr_multi_grant.sv
// Multi-grant round-robin arbiter: grants up to NumGrants requesters per cycle,
// scanning from just after the onehot lowest-priority pointer.
module br_arb_rr_multi_grant #(
  parameter int NumRequesters = 8,
  parameter int NumGrants     = 3
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      enable_priority_update,
  input  logic [NumRequesters-1:0]                  request,
  output logic [NumGrants-1:0][NumRequesters-1:0]   grant,
  output logic [NumGrants-1:0]                      grant_valid,
  output logic [NumRequesters-1:0]                  grant_any,
  output logic [NumRequesters-1:0]                  lowest_prio
);

  localparam int IdxW = (NumRequesters > 1) ? $clog2(NumRequesters) : 1;
  localparam int CntW = $clog2(NumGrants + 1);

  localparam logic [IdxW:0]            NReq      = NumRequesters[IdxW:0];
  localparam logic [IdxW-1:0]          LastIdx   = IdxW'(NumRequesters - 1);
  localparam logic [CntW-1:0]          NGnt      = CntW'(NumGrants);
  localparam logic [NumRequesters-1:0] ResetPrio = {1'b1, {(NumRequesters-1){1'b0}}};

  logic [NumRequesters-1:0]                r_lowest_prio;
  logic [IdxW-1:0]                         w_lp_idx;
  logic [IdxW-1:0]                         w_hp_idx;
  logic [NumGrants-1:0][NumRequesters-1:0] w_grant;
  logic [NumGrants-1:0]                    w_valid;
  logic [NumRequesters-1:0]                w_last;
  logic [NumRequesters-1:0]                w_any;
  logic                                    w_overlap;
  logic                                    w_therm_bad;

  always_comb begin : pointer_decode
    w_lp_idx = '0;
    for (int unsigned i = 0; i < NumRequesters; i++) begin
      if (r_lowest_prio[i]) w_lp_idx = IdxW'(i);
    end
    w_hp_idx = (w_lp_idx == LastIdx) ? '0 : w_lp_idx + IdxW'(1);
  end

  // Wrapped scan; w_last tracks the final requester granted, which becomes
  // the new lowest-priority pointer.
  always_comb begin : scan
    logic [IdxW:0]   sum;
    logic [IdxW-1:0] j;
    logic [CntW-1:0] cnt;
    w_grant = '0;
    w_valid = '0;
    w_last  = '0;
    cnt     = '0;
    sum     = '0;
    j       = '0;
    for (int unsigned i = 0; i < NumRequesters; i++) begin
      sum = {1'b0, w_hp_idx} + (IdxW+1)'(i);
      j   = (sum >= NReq) ? IdxW'(sum - NReq) : sum[IdxW-1:0];
      if (request[j] && (cnt < NGnt)) begin
        w_grant[cnt][j] = 1'b1;
        w_valid[cnt]    = 1'b1;
        w_last          = '0;
        w_last[j]       = 1'b1;
        cnt             = cnt + CntW'(1);
      end
    end
  end

  always_comb begin : outputs
    w_any = '0;
    for (int unsigned k = 0; k < NumGrants; k++) begin
      w_any = w_any | w_grant[k];
    end
    grant       = rst ? '0 : w_grant;
    grant_valid = rst ? '0 : w_valid;
    grant_any   = rst ? '0 : w_any;
    lowest_prio = r_lowest_prio;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lowest_prio <= ResetPrio;
    end else if (enable_priority_update && (|request)) begin
      r_lowest_prio <= w_last;
    end
  end

  always_comb begin : invariants
    logic [NumRequesters-1:0] seen;
    seen        = '0;
    w_overlap   = 1'b0;
    w_therm_bad = 1'b0;
    for (int unsigned k = 0; k < NumGrants; k++) begin
      if (|(seen & w_grant[k])) w_overlap = 1'b1;
      seen = seen | w_grant[k];
    end
    for (int unsigned k = 1; k < NumGrants; k++) begin
      if (w_valid[k] && !w_valid[k-1]) w_therm_bad = 1'b1;
    end
  end

  a_prio_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(r_lowest_prio));
  a_grant_req:   assert property (@(posedge clk) disable iff (rst) (w_any & ~request) == '0);
  a_disjoint:    assert property (@(posedge clk) disable iff (rst) !w_overlap);
  a_thermometer: assert property (@(posedge clk) disable iff (rst) !w_therm_bad);

endmodule

// File: tb/tb_br_arb_rr_multi_grant.sv
// Bench for br_arb_rr_multi_grant (8 requesters, 3 grants): directed vector
// table followed by a randomized run against an independent rotate-based model.
module tb_br_arb_rr_multi_grant;

  localparam int N = 8;
  localparam int G = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [N-1:0]        req;
  logic [G-1:0][N-1:0] grant;
  logic [G-1:0]        gv;
  logic [N-1:0]        gany;
  logic [N-1:0]        lp;

  always #5 clk = ~clk;

  br_arb_rr_multi_grant #(
    .NumRequesters(N),
    .NumGrants    (G)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable_priority_update(en),
    .request               (req),
    .grant                 (grant),
    .grant_valid           (gv),
    .grant_any             (gany),
    .lowest_prio           (lp)
  );

  typedef struct packed {
    logic [G-1:0][N-1:0] g;
    logic [G-1:0]        v;
    logic [N-1:0]        any;
    logic [N-1:0]        lp;
  } exp_t;

  typedef struct packed {
    logic         rst;
    logic         en;
    logic [N-1:0] req;
    exp_t         ex;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv, input int cyc);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, act, expv);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [N-1:0] q,
                              input logic [N-1:0] g0, input logic [N-1:0] g1,
                              input logic [N-1:0] g2, input logic [G-1:0] v,
                              input logic [N-1:0] p);
    vec_t t;
    t.rst    = r;
    t.en     = e;
    t.req    = q;
    t.ex.g   = {g2, g1, g0};
    t.ex.v   = v;
    t.ex.any = g0 | g1 | g2;
    t.ex.lp  = p;
    return t;
  endfunction

  // Reference: rotate request so the highest-priority index lands at bit 0,
  // then peel off lowest set bits.
  function automatic exp_t model(input logic [N-1:0] p, input logic r, input logic [N-1:0] q);
    exp_t         e;
    int           hp;
    int           b;
    logic [2*N-1:0] dbl;
    logic [N-1:0] rot;
    logic [N-1:0] low;
    e    = '0;
    e.lp = p;
    hp   = 0;
    for (int i = 0; i < N; i++) if (p[i]) hp = (i + 1) % N;
    dbl = {q, q} >> hp;
    rot = dbl[N-1:0];
    for (int k = 0; k < G; k++) begin
      if (rot != '0 && !r) begin
        low = rot & (~rot + N'(1));
        b   = 0;
        for (int i = 0; i < N; i++) if (low[i]) b = i;
        e.g[k] = N'(1) << ((b + hp) % N);
        e.v[k] = 1'b1;
        rot    = rot & ~low;
      end
    end
    for (int k = 0; k < G; k++) e.any = e.any | e.g[k];
    return e;
  endfunction

  function automatic logic [N-1:0] next_lp(input logic [N-1:0] p, input logic r,
                                           input logic e, input logic [N-1:0] q,
                                           input exp_t ex);
    logic [N-1:0] n;
    n = p;
    if (r) n = {1'b1, {(N-1){1'b0}}};
    else if (e && q != '0) begin
      for (int k = 0; k < G; k++) if (ex.v[k]) n = ex.g[k];
    end
    return n;
  endfunction

  task automatic step(input logic r, input logic e, input logic [N-1:0] q,
                      input exp_t ex, input int cyc);
    exp_t want;
    @(negedge clk);
    rst = r;
    en  = e;
    req = q;
    sb.push_back(ex);
    #2;
    want = sb.pop_front();
    chk("grant",       32'(grant), 32'(want.g),   cyc);
    chk("grant_valid", 32'(gv),    32'(want.v),   cyc);
    chk("grant_any",   32'(gany),  32'(want.any), cyc);
    chk("lowest_prio", 32'(lp),    32'(want.lp),  cyc);
  endtask

  initial begin
    logic [N-1:0] m_lp;
    logic         r;
    logic         e;
    logic [N-1:0] q;
    exp_t         ex;
    int           streak[N];
    int           max_streak;

    rst = 1'b1;
    en  = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);

    //                 rst   en    req    g0     g1     g2     v      lp
    tbl.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 3'b000, 8'h80));
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 8'h80));
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 8'h80));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h01, 8'h02, 8'h04, 3'b111, 8'h80));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h08, 8'h10, 8'h20, 3'b111, 8'h04));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h40, 8'h80, 8'h01, 3'b111, 8'h20));
    tbl.push_back(mk(1'b0, 1'b0, 8'hFF, 8'h02, 8'h04, 8'h08, 3'b111, 8'h01));
    tbl.push_back(mk(1'b0, 1'b0, 8'hFF, 8'h02, 8'h04, 8'h08, 3'b111, 8'h01));
    tbl.push_back(mk(1'b1, 1'b0, 8'h81, 8'h00, 8'h00, 8'h00, 3'b000, 8'h01));
    tbl.push_back(mk(1'b0, 1'b0, 8'h81, 8'h01, 8'h80, 8'h00, 3'b011, 8'h80));
    tbl.push_back(mk(1'b0, 1'b0, 8'h81, 8'h01, 8'h80, 8'h00, 3'b011, 8'h80));
    tbl.push_back(mk(1'b0, 1'b1, 8'h10, 8'h10, 8'h00, 8'h00, 3'b001, 8'h80));
    tbl.push_back(mk(1'b0, 1'b1, 8'h11, 8'h01, 8'h10, 8'h00, 3'b011, 8'h10));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h20, 8'h40, 8'h80, 3'b111, 8'h10));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h01, 8'h02, 8'h04, 3'b111, 8'h80));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h08, 8'h10, 8'h20, 3'b111, 8'h04));
    tbl.push_back(mk(1'b1, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 3'b000, 8'h20));
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, 8'h01, 8'h02, 8'h04, 3'b111, 8'h80));
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 8'h04));
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000, 8'h04));

    foreach (tbl[i]) step(tbl[i].rst, tbl[i].en, tbl[i].req, tbl[i].ex, i);

    // Directed sequence above leaves the pointer at 0x04.
    m_lp       = 8'h04;
    max_streak = 0;
    for (int i = 0; i < N; i++) streak[i] = 0;

    for (int c = 0; c < 10000; c++) begin
      r = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 7))
        0:       q = '0;
        1:       q = N'(1) << $urandom_range(0, N-1);
        2:       q = N'($urandom) & N'($urandom);
        default: q = N'($urandom);
      endcase
      ex = model(m_lp, r, q);
      step(r, e, q, ex, c + 1000);
      for (int i = 0; i < N; i++) begin
        if (r || !e || !q[i] || gany[i]) streak[i] = 0;
        else streak[i] = streak[i] + 1;
        if (streak[i] > max_streak) max_streak = streak[i];
      end
      m_lp = next_lp(m_lp, r, e, q, ex);
    end
    chk("starvation_streak_le2", 32'(max_streak > 2), 32'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
